// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, compare-result bit layout and response sizing.
package alu_pkg;

  localparam logic [2:0] OP_ADD_RCA = 3'b000;
  localparam logic [2:0] OP_ADD_CLA = 3'b001;
  localparam logic [2:0] OP_ADD_CSA = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_INC     = 3'b100;
  localparam logic [2:0] OP_DEC     = 3'b101;
  localparam logic [2:0] OP_CMP     = 3'b110;
  localparam logic [2:0] OP_PASS    = 3'b111;

  localparam int CMP_GT_BIT = 0;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 2;

  // y + cout + zero; the tag is appended by the user of the FIFO
  localparam int RSP_DATA_W = 8 + 1 + 1;

  typedef struct packed {
    logic [7:0] y;
    logic       cout;
    logic       zero;
  } alu_res_t;

  function automatic int rsp_w(input int tag_w);
    return RSP_DATA_W + tag_w;
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU with three adder structures, sub, inc/dec, compare and pass.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] op,
  output logic [7:0] Y,
  output logic       Cout
);

  logic [7:0] rca_s;
  logic       rca_c;
  logic [7:0] cla_g, cla_p;
  logic [8:0] cla_c;
  logic [4:0] csa_lo, csa_hi0, csa_hi1;
  logic [8:0] sub_d;

  always_comb begin
    rca_c = 1'b0;
    rca_s = '0;
    for (int i = 0; i < 8; i++) begin
      rca_s[i] = A[i] ^ B[i] ^ rca_c;
      rca_c    = (A[i] & B[i]) | (rca_c & (A[i] ^ B[i]));
    end
  end

  assign cla_g = A & B;
  assign cla_p = A ^ B;
  always_comb begin
    cla_c    = '0;
    for (int i = 0; i < 8; i++)
      cla_c[i+1] = cla_g[i] | (cla_p[i] & cla_c[i]);
  end

  // carry-select: both upper-nibble sums precomputed, low carry picks one
  assign csa_lo  = {1'b0, A[3:0]} + {1'b0, B[3:0]};
  assign csa_hi0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
  assign csa_hi1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;

  assign sub_d = {1'b0, A} - {1'b0, B};

  always_comb begin
    Y    = '0;
    Cout = 1'b0;
    case (op)
      OP_ADD_RCA: begin Y = rca_s;            Cout = rca_c;    end
      OP_ADD_CLA: begin Y = cla_p ^ cla_c[7:0]; Cout = cla_c[8]; end
      OP_ADD_CSA: begin
        Y    = {(csa_lo[4] ? csa_hi1[3:0] : csa_hi0[3:0]), csa_lo[3:0]};
        Cout = csa_lo[4] ? csa_hi1[4] : csa_hi0[4];
      end
      OP_SUB:     begin Y = sub_d[7:0];       Cout = ~sub_d[8]; end
      OP_INC:     begin Y = A + 8'd1;         Cout = &A;        end
      OP_DEC:     begin Y = A - 8'd1;         Cout = |A;        end
      OP_CMP: begin
        Y[CMP_LT_BIT] = (A < B);
        Y[CMP_EQ_BIT] = (A == B);
        Y[CMP_GT_BIT] = (A > B);
      end
      default:    begin Y = A;                Cout = 1'b0;      end
    endcase
  end

endmodule

// File: rtl/alu_resp_unit.sv
// Command/response front end: one ALU evaluation per accepted command, results queued
// in an in-order FIFO with tag and zero flag, popped over a valid/ready handshake.
module alu_resp_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_y,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_done
);

  localparam int           PW      = $clog2(DEPTH);
  localparam int           RSP_W   = rsp_w(TAG_W);
  localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);

  logic [7:0]       alu_y;
  logic             alu_cout;
  alu_res_t         res;
  logic [RSP_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW:0]      count;
  logic             push, pop;

  alu_8bit u_alu (
    .A    (cmd_a),
    .B    (cmd_b),
    .op   (cmd_op),
    .Y    (alu_y),
    .Cout (alu_cout)
  );

  assign res = '{y: alu_y, cout: alu_cout, zero: (alu_y == 8'h00)};

  // handshakes depend only on registered count, never on the opposite side's inputs
  assign cmd_ready = (count < DEPTH_C);
  assign rsp_valid = (count != '0);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = rsp_valid & rsp_ready;

  assign {rsp_y, rsp_cout, rsp_zero, rsp_tag} = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {res, cmd_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ops_done <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr     <= rptr + 1'b1;
        ops_done <= ops_done + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed bench for alu_resp_unit: queue-based reference model checked every cycle,
// plus literal expectations from hand-computed vectors.
module tb_alu_resp_unit;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_y;
  logic             rsp_cout, rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] ops_done;

  alu_resp_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]       y;
    logic             cout;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             mq[$];
  logic [CNT_W-1:0] m_ops = '0;
  bit               started = 0;

  function automatic exp_t alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic [TAG_W-1:0] tag);
    exp_t e;
    int ia = int'(a);
    int ib = int'(b);
    int r  = 0;
    bit c  = 0;
    case (op)
      3'd0, 3'd1, 3'd2: begin r = ia + ib; c = (r > 255); end
      3'd3: begin r = ia - ib + 256; c = (ia >= ib); end
      3'd4: begin r = ia + 1; c = (ia == 255); end
      3'd5: begin r = ia + 255; c = (ia != 0); end
      3'd6: begin r = (ia < ib) * 4 + (ia == ib) * 2 + (ia > ib); c = 0; end
      default: begin r = ia; c = 0; end
    endcase
    e.y    = 8'(r % 256);
    e.cout = c;
    e.tag  = tag;
    return e;
  endfunction

  always @(posedge clk) begin
    started <= 1;
    if (!rst_n) begin
      mq.delete();
      m_ops = '0;
    end else begin
      bit can_push;
      can_push = (mq.size() < DEPTH);
      if (rsp_ready && mq.size() != 0) begin
        void'(mq.pop_front());
        m_ops = m_ops + 1'b1;
      end
      if (cmd_valid && can_push) mq.push_back(alu_ref(cmd_op, cmd_a, cmd_b, cmd_tag));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      chk("rsp_valid", 32'(rsp_valid), 32'(mq.size() != 0));
      chk("ops_done", 32'(ops_done), 32'(m_ops));
      if (mq.size() != 0) begin
        chk("rsp_y", 32'(rsp_y), 32'(mq[0].y));
        chk("rsp_cout", 32'(rsp_cout), 32'(mq[0].cout));
        chk("rsp_zero", 32'(rsp_zero), 32'(mq[0].y == 8'h00));
        chk("rsp_tag", 32'(rsp_tag), 32'(mq[0].tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    drive(3'd0, 8'h11, 8'h22, 4'h0);
    step(); step();
    at_neg();
    chk("rst cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst ops_done", 32'(ops_done), 32'h0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    step();
    at_neg();
    chk("post-rst cmd_ready", 32'(cmd_ready), 32'h1);
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'h0);

    // single add
    drive(3'd0, 8'h3C, 8'h27, 4'h1); rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    at_neg();
    chk("add valid", 32'(rsp_valid), 32'h1);
    chk("add y", 32'(rsp_y), 32'h63);
    chk("add cout", 32'(rsp_cout), 32'h0);
    chk("add zero", 32'(rsp_zero), 32'h0);
    chk("add tag", 32'(rsp_tag), 32'h1);
    step();
    at_neg();
    chk("add ops_done", 32'(ops_done), 32'h1);

    // back-to-back wrap/zero, one response per cycle
    drive(3'd4, 8'hFF, 8'h00, 4'h2);
    step();
    drive(3'd5, 8'h00, 8'h00, 4'h3);
    at_neg();
    chk("inc y", 32'(rsp_y), 32'h00);
    chk("inc cout", 32'(rsp_cout), 32'h1);
    chk("inc zero", 32'(rsp_zero), 32'h1);
    step();
    drive(3'd6, 8'h40, 8'h20, 4'h4);
    at_neg();
    chk("dec y", 32'(rsp_y), 32'hFF);
    chk("dec cout", 32'(rsp_cout), 32'h0);
    step();
    cmd_valid = 1'b0;
    at_neg();
    chk("cmp y", 32'(rsp_y), 32'h01);
    chk("cmp cout", 32'(rsp_cout), 32'h0);
    step();
    at_neg();
    chk("b2b ops_done", 32'(ops_done), 32'h4);

    // backpressure: third command held until space frees
    rsp_ready = 1'b0;
    drive(3'd3, 8'h50, 8'h20, 4'h5); step();
    drive(3'd7, 8'hAA, 8'h00, 4'h6); step();
    drive(3'd2, 8'hB5, 8'h6E, 4'h7); step();
    at_neg();
    chk("bp full ready", 32'(cmd_ready), 32'h0);
    step();
    at_neg();
    chk("bp held ready", 32'(cmd_ready), 32'h0);
    chk("bp sub y", 32'(rsp_y), 32'h30);
    chk("bp sub cout", 32'(rsp_cout), 32'h1);
    rsp_ready = 1'b1;
    step();
    at_neg();
    chk("bp pass y", 32'(rsp_y), 32'hAA);
    chk("bp pass cout", 32'(rsp_cout), 32'h0);
    step();
    cmd_valid = 1'b0;
    at_neg();
    chk("bp csa y", 32'(rsp_y), 32'h23);
    chk("bp csa cout", 32'(rsp_cout), 32'h1);
    chk("bp csa tag", 32'(rsp_tag), 32'h7);
    step();
    at_neg();
    // four pops before this section, three within it
    chk("bp ops_done", 32'(ops_done), 32'h7);

    // mixed opcode stream with intermittent rsp_ready
    vecs[0] = '{3'd3, 8'h5A, 8'h5A};
    vecs[1] = '{3'd0, 8'h80, 8'h80};
    vecs[2] = '{3'd6, 8'h33, 8'h33};
    vecs[3] = '{3'd1, 8'h0F, 8'h01};
    vecs[4] = '{3'd5, 8'h01, 8'h00};
    vecs[5] = '{3'd7, 8'h00, 8'h9C};
    vecs[6] = '{3'd4, 8'h7F, 8'h00};
    vecs[7] = '{3'd2, 8'hFF, 8'h01};
    for (int i = 0; i < 8; i++) begin
      bit acc;
      int tries;
      acc = 0;
      tries = 0;
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i + 8));
      rsp_ready = (i % 3 != 0);
      while (!acc && tries < 20) begin
        at_neg();
        acc = (mq.size() < DEPTH);
        step();
        rsp_ready = 1'b1;
        tries++;
      end
      if (!acc) chk("stream accept timeout", 32'(tries), 32'h0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) step();
    at_neg();
    chk("stream drained", 32'(rsp_valid), 32'h0);

    // reset while full
    rsp_ready = 1'b0;
    drive(3'd0, 8'h01, 8'h01, 4'h8); step();
    drive(3'd0, 8'h02, 8'h02, 4'h9); step();
    cmd_valid = 1'b0;
    at_neg();
    chk("pre-rst full", 32'(cmd_ready), 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    at_neg();
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid-rst cmd_ready", 32'(cmd_ready), 32'h1);
    chk("mid-rst ops_done", 32'(ops_done), 32'h0);
    drive(3'd5, 8'h10, 8'h00, 4'hA); rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    at_neg();
    chk("post-rst y", 32'(rsp_y), 32'h0F);
    chk("post-rst cout", 32'(rsp_cout), 32'h1);
    chk("post-rst tag", 32'(rsp_tag), 32'hA);
    step();
    at_neg();
    chk("post-rst ops_done", 32'(ops_done), 32'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
